// File: rtl/pipeline_stage_skid.sv
// Two-entry pipeline register with a skid slot. It gives a registered in_ready
// and full throughput, and keeps statistics on stall and flush cycles.
module pipeline_stage_skid #(
  parameter int                 DATA_W   = 128,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic m_valid;
  logic accept;
  logic drain;

  assign m_valid = (state_q != EMPTY);
  assign accept  = in_valid & in_ready_q;
  assign drain   = m_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (accept && drain) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (accept) begin
          state_d  = FULL;
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d  = ONE;
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A flush leaves the payload registers alone; the EMPTY state masks them.
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = m_data_q;
      m_ctrl_d = m_ctrl_q;
      s_data_d = s_data_q;
      s_ctrl_d = s_ctrl_q;
    end

    // The ready signal is registered, so it is derived from the next state.
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && m_valid && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_valid ? m_data_q : '0;
  assign out_ctrl  = m_valid ? m_ctrl_q : CTRL_NOP;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Directed bench for pipeline_stage_skid. Accepted beats are queued as expectations,
// and a monitor checks every drained beat against the head of that queue.
module tb_pipeline_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  pipeline_stage_skid #(
    .DATA_W(32), .CTRL_W(8), .CTRL_NOP(8'h5A), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } beat_t;

  beat_t sb_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    n_pop   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input logic iv, input logic [31:0] d, input logic [7:0] c,
                     input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a drain is seen before the edge that completes it.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", 64'(out_data), 64'hDEAD);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        n_pop++;
        chk("beat", {24'h0, out_data, out_ctrl}, {24'h0, e.d, e.c});
      end
    end
  end

  // Expectation pusher runs after the monitor, so a drain in a flush cycle still counts.
  always @(negedge clk) begin
    #1;
    if (rst || flush) sb_q.delete();
    else if (in_valid && in_ready) sb_q.push_back('{d: in_data, c: in_ctrl});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'h5A);
    chk("rst_cnts", 64'({stall_cnt, flush_cnt}), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Streaming
    cyc(1'b1, 32'h11, 8'h01, 1'b1, 1'b0);
    chk("stream_ready1", 64'(in_ready), 64'd1);
    chk("stream_first_latency", 64'(out_data), 64'h11);
    cyc(1'b1, 32'h22, 8'h02, 1'b1, 1'b0);
    chk("stream_ready2", 64'(in_ready), 64'd1);
    cyc(1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
    chk("stream_ready3", 64'(in_ready), 64'd1);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("stream_empty", 64'(out_valid), 64'd0);

    // Backpressure
    cyc(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_data", 64'(out_data), 64'hA);
    cyc(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("bp_hold_data2", 64'(out_data), 64'hA);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("bp_stall_cnt", 64'(stall_cnt), 64'd2);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush from FULL with a beat offered
    cyc(1'b1, 32'hA2, 8'h1A, 1'b0, 1'b0);
    cyc(1'b1, 32'hB2, 8'h1B, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 8'h0C, 1'b0, 1'b1);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_ctrl", 64'(out_ctrl), 64'h5A);
    chk("fl_out_data", 64'(out_data), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_cnt", 64'(flush_cnt), 64'd1);
    chk("fl_stall_cnt", 64'(stall_cnt), 64'd4);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    // Flush in EMPTY with a beat offered: discarded, counter untouched
    cyc(1'b1, 32'hD, 8'h0D, 1'b1, 1'b1);
    chk("fl_empty_cnt", 64'(flush_cnt), 64'd1);
    chk("fl_empty_valid", 64'(out_valid), 64'd0);
    // Drain during a flush cycle completes downstream
    cyc(1'b1, 32'hE, 8'h0E, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b1);
    chk("fl_drain_cnt", 64'(flush_cnt), 64'd2);
    chk("fl_drain_valid", 64'(out_valid), 64'd0);

    // Stall counter saturation
    cyc(1'b1, 32'hF, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);
    chk("sat_hold_data", 64'(out_data), 64'hF);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    chk("sat_after_drain", 64'(stall_cnt), 64'd15);

    // Asynchronous reset while ONE
    cyc(1'b1, 32'h66, 8'h06, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_cnts", 64'({stall_cnt, flush_cnt}), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_out_ctrl", 64'(out_ctrl), 64'h5A);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_ready_rise", 64'(in_ready), 64'd1);
    cyc(1'b1, 32'h77, 8'h07, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

    chk("sb_left", 64'(sb_q.size()), 64'd0);
    chk("beats_out", 64'(n_pop), 64'd8);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
